// File: rtl/serial_frame_deser.sv
// serial_frame_deser: framed serial-to-parallel receiver with a 1-deep valid/ready output buffer.
// Define SERIAL_FRAME_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_frame_deser #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] sr;
    logic par_bad, last_bit, stop_beat, good, load;

    assign last_bit  = cnt == CW'(DATA_W - 1);
    assign stop_beat = sin_valid && state == STOP;
    assign good      = stop_beat && sin && !par_bad;
    assign load      = good && (!dout_valid || dout_ready);
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (sin_valid && !sin) ? DATA : IDLE;
            DATA:    state_nx = (sin_valid && last_bit) ? AFTER_DATA : DATA;
            PARITY:  state_nx = sin_valid ? STOP : PARITY;
            STOP:    state_nx = sin_valid ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_err <= stop_beat && !(sin && !par_bad);
            overrun   <= good && dout_valid && !dout_ready;
            if (state == DATA && sin_valid) begin
                sr  <= MSB_FIRST ? {sr[DATA_W-2:0], sin} : {sin, sr[DATA_W-1:1]};
                cnt <= last_bit ? '0 : cnt + 1'b1;
            end
            // a word arriving in the same cycle the old one is taken keeps dout_valid high
            if (load) begin
                dout       <= sr;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef SERIAL_FRAME_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_bad <= 1'b0;
        else if (state == PARITY && sin_valid) par_bad <= sin != ^sr;
    end
`else
    assign par_bad = 1'b0;
`endif
endmodule
